msu_audio_sample_out: RTL and testbench
=======================================

Name: msu_audio_sample_out

Overview:
- Downstream consumer of the MSU audio sector fetcher.
- Accepts the 16-bit words the fetcher streams out of SD sectors and buffers them in an internal FIFO.
- Reports FIFO fill back to the fetcher as its throttle input (the fetcher stops requesting at 1792 words).
- Pops interleaved L/R signed 16-bit PCM at the sample rate, applies an 8-bit volume and presents registered stereo samples to the audio mixer.

Parameters:
- CLK_HZ, 21477270, system clock frequency in Hz.
- SAMPLE_HZ, 44100, output sample rate in Hz. CLK_HZ/SAMPLE_HZ must be >= 8.
- FIFO_AW, 11, FIFO address width; depth = 2**FIFO_AW words.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  one-cycle pulse on new track trigger; empties FIFO and clears flags.
- wr_en  in  1  word valid from fetcher (sd_ack & sd_buff_wr).
- wr_data  in  16  PCM word; even-index words are L, odd-index words are R.
- play_enable  in  1  high = consume samples at rate; low = hold FIFO, output silence.
- volume  in  8  linear gain; 8'hFF = unity.
- fifo_usedw  out  FIFO_AW+1  current word count, fed to the fetcher's throttle.
- fifo_full  out  1  usedw == depth.
- audio_l  out  16  signed left sample, registered.
- audio_r  out  16  signed right sample, registered.
- sample_strobe  out  1  one-cycle pulse when audio_l/audio_r update.
- underrun  out  1  sticky; set when a tick finds fewer than 2 words while playing.
- overflow  out  1  sticky; set when wr_en arrives while full (word dropped).

Behaviour:
- Reset values:
  - outputs: audio_l/audio_r 0, sample_strobe 0, underrun 0, overflow 0, fifo_usedw 0, fifo_full 0.
  - internal state: FIFO pointers 0, phase accumulator 0, FSM IDLE, L/R lane toggle 0.
- Tick generator:
  - acc (>= 32 bits) += SAMPLE_HZ each clk.
  - When acc + SAMPLE_HZ >= CLK_HZ: acc <= acc + SAMPLE_HZ - CLK_HZ and tick = 1 for one cycle.
  - Runs continuously, including when play_enable is low. Reset clears it; flush does not.
- FIFO:
  - Single-clock, registered-read RAM with 1-cycle read latency.
  - Write and read in the same cycle: usedw unchanged.
  - Write when full: dropped, overflow <= 1.
  - Read is never issued when empty.
  - flush has priority over a same-cycle write and read: pointers and usedw go to 0, underrun/overflow clear, FSM returns to IDLE, and the write is discarded.
- FSM states: IDLE, RD_L, RD_R, LATCH.
  - IDLE: on tick,
    - if play_enable and usedw >= 2: issue read of L, go to RD_L;
    - else: audio_l/audio_r <= 0 and pulse sample_strobe. If play_enable, also underrun <= 1. Stay in IDLE.
  - RD_L: capture L data, issue read of R, go to RD_R.
  - RD_R: capture R data, go to LATCH.
  - LATCH: write scaled L/R to the outputs, pulse sample_strobe, go to IDLE.
  - Latency: tick -> sample_strobe = 3 clk when playing, 0 clk (same-cycle registered update) when silent.
  - A tick arriving outside IDLE is ignored; this cannot occur given the ratio constraint.
- Scaling:
  - volume == 8'hFF: output = sample exactly.
  - Otherwise: output = (signed sample * {1'b0, volume}) >>> 8, using a 25-bit signed product, arithmetic shift, truncation toward minus infinity, no saturation needed.
  - Volume is sampled in LATCH.
- L/R alignment:
  - The lane toggle tracks word parity from flush.
  - If the first word after flush is never consumed, alignment is still preserved because pops are always in pairs.
- Simultaneous flush and tick: flush wins, no strobe that cycle.
- play_enable dropping mid-pop: the current pair completes; subsequent ticks output silence with no underrun.

Test Plan (bench params: CLK_HZ=100, SAMPLE_HZ=10, FIFO_AW=4):
- Tick rate: hold reset 2 clk, release, play_enable=0 -> sample_strobe every 10 clk, audio_l = audio_r = 0, underrun stays 0.
- Basic playback: write 16'h1234, 16'hFEDC, 16'h0100, 16'h8000; play_enable=1, volume=FF:
  - next strobe gives L=1234, R=FEDC;
  - the following strobe gives L=0100, R=8000;
  - usedw steps 4 -> 2 -> 0;
  - 3 clk from tick to strobe.
- Volume: write L=16'h4000, R=16'hC000, volume=8'h80 -> L=16'h2000, R=16'hE000. Volume=8'h00 -> 0, 0.
- Underrun: FIFO holds 1 word, play_enable=1, tick -> outputs 0, strobe pulses, underrun=1 and stays 1 until flush. The word remains (usedw=1).
- Full/overflow: write 17 words -> fifo_full=1 at 16, overflow=1, usedw=16. Write and read in the same cycle while full -> usedw stays 16 and the write is accepted.
- Flush priority: assert flush, wr_en and tick in the same cycle with usedw=6 -> usedw=0, flags cleared, no strobe. The next tick gives silence with underrun set.

Source files
------------

// File: rtl/msu_audio_sample_out.sv
// rtl/msu_audio_sample_out.sv - MSU audio word FIFO, sample-rate pacing, volume scaling
// and registered stereo output to the mixer.
module msu_audio_sample_out #(
  parameter int unsigned CLK_HZ    = 21477270,
  parameter int unsigned SAMPLE_HZ = 44100,
  parameter int unsigned FIFO_AW   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [15:0]        wr_data,
  input  logic               play_enable,
  input  logic [7:0]         volume,
  output logic [FIFO_AW:0]   fifo_usedw,
  output logic               fifo_full,
  output logic [15:0]        audio_l,
  output logic [15:0]        audio_r,
  output logic               sample_strobe,
  output logic               underrun,
  output logic               overflow
);

  localparam int unsigned    DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_W = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] TWO_W   = (FIFO_AW + 1)'(2);
  localparam logic [32:0]    CLK_W   = 33'(CLK_HZ);
  localparam logic [32:0]    SMP_W   = 33'(SAMPLE_HZ);

  typedef enum logic [1:0] {IDLE, RD_L, RD_R, LATCH} state_t;

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [32:0]        acc_sum;
  logic               tick;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   usedw_q, usedw_d;
  logic               lane_q, lane_d;
  logic [15:0]        l_raw_q, l_raw_d, r_raw_q, r_raw_d;
  logic [15:0]        audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic               strobe_q, strobe_d;
  logic               underrun_q, underrun_d, overflow_q, overflow_d;
  logic               rd_en, wr_acc, full;
  logic [15:0]        rd_data_q;
  logic [15:0]        mem [DEPTH];

  // Unity gain bypasses the multiplier so 8'hFF is bit-exact instead of 255/256.
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [7:0] v);
    logic signed [24:0] p;
    if (v == 8'hFF) return s;
    p = $signed(s) * $signed({1'b0, v});
    return 16'(p >>> 8);
  endfunction

  always_comb begin
    acc_sum = {1'b0, acc_q} + SMP_W;
    tick    = (acc_sum >= CLK_W);
    acc_d   = tick ? 32'(acc_sum - CLK_W) : acc_sum[31:0];
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    l_raw_d    = l_raw_q;
    r_raw_d    = r_raw_q;
    audio_l_d  = audio_l_q;
    audio_r_d  = audio_r_q;
    strobe_d   = 1'b0;
    underrun_d = underrun_q;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (play_enable && (usedw_q >= TWO_W)) begin
            rd_en   = 1'b1;
            state_d = RD_L;
          end else begin
            audio_l_d = 16'h0000;
            audio_r_d = 16'h0000;
            strobe_d  = 1'b1;
            if (play_enable) underrun_d = 1'b1;
          end
        end
      end
      RD_L: begin
        if (lane_q) r_raw_d = rd_data_q;
        else        l_raw_d = rd_data_q;
        lane_d  = ~lane_q;
        rd_en   = 1'b1;
        state_d = RD_R;
      end
      RD_R: begin
        if (lane_q) r_raw_d = rd_data_q;
        else        l_raw_d = rd_data_q;
        lane_d  = ~lane_q;
        state_d = LATCH;
      end
      LATCH: begin
        audio_l_d = scale(l_raw_q, volume);
        audio_r_d = scale(r_raw_q, volume);
        strobe_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new track abandons any pop in flight and suppresses a coincident strobe.
    if (flush) begin
      state_d    = IDLE;
      lane_d     = 1'b0;
      audio_l_d  = audio_l_q;
      audio_r_d  = audio_r_q;
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      rd_en      = 1'b0;
    end
  end

  always_comb begin
    full       = (usedw_q == DEPTH_W);
    wr_acc     = wr_en && (!full || rd_en) && !flush;
    overflow_d = overflow_q | (wr_en && full && !rd_en);
    wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    usedw_d    = usedw_q;
    if (wr_acc && !rd_en)      usedw_d = usedw_q + 1'b1;
    else if (!wr_acc && rd_en) usedw_d = usedw_q - 1'b1;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      usedw_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
    if (rd_en)  rd_data_q     <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usedw_q    <= '0;
      lane_q     <= 1'b0;
      l_raw_q    <= '0;
      r_raw_q    <= '0;
      audio_l_q  <= '0;
      audio_r_q  <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      usedw_q    <= usedw_d;
      lane_q     <= lane_d;
      l_raw_q    <= l_raw_d;
      r_raw_q    <= r_raw_d;
      audio_l_q  <= audio_l_d;
      audio_r_q  <= audio_r_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign fifo_usedw    = usedw_q;
  assign fifo_full     = full;
  assign audio_l       = audio_l_q;
  assign audio_r       = audio_r_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_msu_audio_sample_out.sv
// tb/tb_msu_audio_sample_out.sv - directed bench with a queue-based reference model
// compared against the DUT every cycle.
module tb_msu_audio_sample_out;

  localparam int CLK_HZ = 100;
  localparam int SAMPLE_HZ = 10;
  localparam int FIFO_AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic play_enable = 1'b0;
  logic [7:0] volume = 8'hFF;
  logic [FIFO_AW:0] fifo_usedw;
  logic fifo_full;
  logic [15:0] audio_l, audio_r;
  logic sample_strobe, underrun, overflow;

  msu_audio_sample_out #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .play_enable(play_enable), .volume(volume), .fifo_usedw(fifo_usedw),
    .fifo_full(fifo_full), .audio_l(audio_l), .audio_r(audio_r),
    .sample_strobe(sample_strobe), .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue, the rate rule, and a countdown to the output update.
  logic [15:0] q[$];
  int acc = 0;
  int pend = 0;
  logic [15:0] pl, pr, m_l, m_r;
  bit m_strobe, m_und, m_ovf, m_tick, rd, started;

  function automatic logic [15:0] ref_scale(input logic [15:0] s, input logic [7:0] v);
    int p;
    if (v == 8'hFF) return s;
    p = int'($signed(s)) * int'(v);
    p = p >>> 8;
    return p[15:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      acc = 0; q.delete(); pend = 0; m_l = 0; m_r = 0;
      m_strobe = 0; m_und = 0; m_ovf = 0;
    end else begin
      m_tick = (acc + SAMPLE_HZ >= CLK_HZ);
      acc = m_tick ? acc + SAMPLE_HZ - CLK_HZ : acc + SAMPLE_HZ;
      m_strobe = 0;
      rd = 0;
      if (flush) begin
        q.delete(); pend = 0; m_und = 0; m_ovf = 0;
      end else begin
        if (pend == 3) begin
          pr = q.pop_front(); rd = 1; pend = 2;
        end else if (pend == 2) begin
          pend = 1;
        end else if (pend == 1) begin
          m_l = ref_scale(pl, volume); m_r = ref_scale(pr, volume);
          m_strobe = 1; pend = 0;
        end else if (m_tick) begin
          if (play_enable && q.size() >= 2) begin
            pl = q.pop_front(); rd = 1; pend = 3;
          end else begin
            m_l = 0; m_r = 0; m_strobe = 1;
            if (play_enable) m_und = 1;
          end
        end
        if (wr_en) begin
          if (q.size() < DEPTH || rd) q.push_back(wr_data);
          else m_ovf = 1;
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("usedw", 32'(fifo_usedw), q.size());
      check("full", 32'(fifo_full), 32'(q.size() == DEPTH));
      check("strobe", 32'(sample_strobe), 32'(m_strobe));
      check("audio_l", 32'(audio_l), 32'(m_l));
      check("audio_r", 32'(audio_r), 32'(m_r));
      check("underrun", 32'(underrun), 32'(m_und));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_en = 1'b1; wr_data = w;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_strobe && n < 30);
    if (!sample_strobe) check("strobe_timeout", 0, 1);
  endtask

  int n;

  initial begin
    step(); step();
    check("rst_usedw", 32'(fifo_usedw), 0);
    check("rst_audio", {audio_l, audio_r}, 0);
    check("rst_flags", {29'd0, sample_strobe, underrun, overflow}, 0);
    reset = 1'b0;

    // Idle pacing
    wait_strobe(n); check("first_tick", n, 10);
    wait_strobe(n); check("tick_period", n, 10);
    check("idle_audio", {audio_l, audio_r}, 0);
    check("idle_underrun", 32'(underrun), 0);

    // Basic playback and tick->strobe latency
    write_word(16'h1234); write_word(16'hFEDC);
    write_word(16'h0100); write_word(16'h8000);
    check("usedw4", 32'(fifo_usedw), 4);
    wait_strobe(n);
    play_enable = 1'b1; volume = 8'hFF;
    wait_strobe(n); check("play_latency", n, 13);
    check("pair1", {audio_l, audio_r}, 32'h1234FEDC);
    check("usedw2", 32'(fifo_usedw), 2);
    wait_strobe(n); check("play_period", n, 10);
    check("pair2", {audio_l, audio_r}, 32'h01008000);
    check("usedw0", 32'(fifo_usedw), 0);
    play_enable = 1'b0;

    // Volume
    write_word(16'h4000); write_word(16'hC000);
    write_word(16'h4000); write_word(16'hC000);
    wait_strobe(n);
    volume = 8'h80; play_enable = 1'b1;
    wait_strobe(n); check("vol80", {audio_l, audio_r}, 32'h2000E000);
    volume = 8'h00;
    wait_strobe(n); check("vol00", {audio_l, audio_r}, 32'h00000000);
    play_enable = 1'b0;

    // Underrun with a single buffered word
    write_word(16'h1111);
    wait_strobe(n);
    play_enable = 1'b1;
    wait_strobe(n);
    check("und_audio", {audio_l, audio_r}, 0);
    check("und_set", 32'(underrun), 1);
    check("und_usedw", 32'(fifo_usedw), 1);
    wait_strobe(n);
    check("und_sticky", 32'(underrun), 1);
    play_enable = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_usedw", 32'(fifo_usedw), 0);
    check("flush_und", 32'(underrun), 0);

    // Full and overflow
    volume = 8'hFF;
    for (int i = 0; i < 17; i++) begin
      write_word(16'h0A00 + 16'(i));
      if (i == 15) check("full_at16", 32'(fifo_full), 1);
    end
    check("ovf_set", 32'(overflow), 1);
    check("ovf_usedw", 32'(fifo_usedw), 16);
    wait_strobe(n);
    repeat (9) step();
    wr_en = 1'b1; wr_data = 16'h5555; play_enable = 1'b1;
    step();
    wr_en = 1'b0;
    check("full_rw_usedw", 32'(fifo_usedw), 16);
    step();
    check("full_rw_next", 32'(fifo_usedw), 15);
    wait_strobe(n);
    check("full_pair", {audio_l, audio_r}, 32'h0A000A01);
    play_enable = 1'b0;

    // Flush against a coincident write and tick
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 6; i++) write_word(16'h0B00 + 16'(i));
    check("pre_flush_usedw", 32'(fifo_usedw), 6);
    wait_strobe(n);
    repeat (9) step();
    flush = 1'b1; wr_en = 1'b1; wr_data = 16'h7777; play_enable = 1'b1;
    step();
    flush = 1'b0; wr_en = 1'b0;
    check("fp_usedw", 32'(fifo_usedw), 0);
    check("fp_nostrobe", 32'(sample_strobe), 0);
    check("fp_flags", {30'd0, underrun, overflow}, 0);
    wait_strobe(n); check("fp_next_tick", n, 10);
    check("fp_silence", {audio_l, audio_r}, 0);
    check("fp_underrun", 32'(underrun), 1);
    play_enable = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
